// File: rtl/nios_timer_pkg.sv
// Shared definitions for nios_timer_master: timer register map, control bits and FSM states.
// The SNAP_* states exist only when NIOS_TIMER_MASTER_SNAPSHOT_EN is defined.
package nios_timer_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_PL,
      S_WR_PH,
      S_WR_CTRL,
      S_RUN,
      S_CLR_TO,
      S_STOP
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
      ,
      S_SNAP_W,
      S_SNAP_RL,
      S_SNAP_RH,
      S_SNAP_DONE
`endif
   } state_t;

   // The timer counts L..0, so a period of N cycles needs L = N-1; 0 and 1 clamp to 1.
   function automatic logic [31:0] load_value(input logic [31:0] period);
      return (period < 32'd2) ? 32'd1 : period - 32'd1;
   endfunction

endpackage

// File: rtl/nios_timer_master.sv
// Avalon-MM initiator that programs the interval timer, services its timeout and emits ticks.
// Define NIOS_TIMER_MASTER_SNAPSHOT_EN to add the counter snapshot readback path.
module nios_timer_master
   import nios_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_period,
   input  logic        cfg_continuous,
   input  logic        stop_req,
   input  logic        snap_req,
   output logic        snap_valid,
   output logic [31:0] snap_value,
   output logic        tick,
   output logic [15:0] tick_count,
   output logic        busy,
   output logic [2:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [15:0] writedata,
   input  logic [15:0] readdata,
   input  logic        irq
);

   state_t      state_q, state_d;
   logic [31:0] load_q, load_d;
   logic        cont_q, cont_d;
   logic        stop_pend_q, stop_pend_d;
   logic [15:0] tick_count_q, tick_count_d;

`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
   logic        snap_pend_q, snap_pend_d;
   logic [15:0] snap_lo_q, snap_lo_d;
   logic [31:0] snap_value_q, snap_value_d;
   logic        snap_valid_d;
`else
   logic        unused_snap;
   assign unused_snap = snap_req ^ (^readdata);
`endif

   always_comb begin
      state_d      = state_q;
      load_d       = load_q;
      cont_d       = cont_q;
      stop_pend_d  = stop_pend_q | stop_req;
      tick_count_d = tick_count_q;
      chipselect   = 1'b0;
      write_n      = 1'b1;
      address      = ADDR_STATUS;
      writedata    = '0;
      tick         = 1'b0;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
      snap_pend_d  = snap_pend_q | snap_req;
      snap_lo_d    = snap_lo_q;
      snap_value_d = snap_value_q;
      snap_valid_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               load_d  = load_value(cfg_period);
               cont_d  = cfg_continuous;
               state_d = S_WR_PL;
            end
         end
         S_WR_PL: begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = ADDR_PERIODL;
            writedata  = load_q[15:0];
            state_d    = S_WR_PH;
         end
         S_WR_PH: begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = ADDR_PERIODH;
            writedata  = load_q[31:16];
            state_d    = S_WR_CTRL;
         end
         S_WR_CTRL: begin
            chipselect             = 1'b1;
            write_n                = 1'b0;
            address                = ADDR_CONTROL;
            writedata[CTRL_ITO]    = 1'b1;
            writedata[CTRL_CONT]   = cont_q;
            writedata[CTRL_START]  = 1'b1;
            state_d                = S_RUN;
         end
         S_RUN: begin
            // A request pulsed this very cycle is honoured without waiting for the latch.
            if (irq)
               state_d = S_CLR_TO;
            else if (stop_pend_d)
               state_d = S_STOP;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
            else if (snap_pend_d)
               state_d = S_SNAP_W;
`endif
         end
         S_CLR_TO: begin
            chipselect   = 1'b1;
            write_n      = 1'b0;
            address      = ADDR_STATUS;
            tick         = 1'b1;
            tick_count_d = tick_count_q + 16'd1;
            state_d      = cont_q ? S_RUN : S_IDLE;
         end
         S_STOP: begin
            chipselect           = 1'b1;
            write_n              = 1'b0;
            address              = ADDR_CONTROL;
            writedata[CTRL_STOP] = 1'b1;
            stop_pend_d          = 1'b0;
            state_d              = S_IDLE;
         end
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
         S_SNAP_W: begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            address    = ADDR_SNAPL;
            state_d    = S_SNAP_RL;
         end
         S_SNAP_RL: begin
            chipselect = 1'b1;
            address    = ADDR_SNAPL;
            state_d    = S_SNAP_RH;
         end
         S_SNAP_RH: begin
            chipselect = 1'b1;
            address    = ADDR_SNAPH;
            snap_lo_d  = readdata;
            state_d    = S_SNAP_DONE;
         end
         S_SNAP_DONE: begin
            snap_value_d = {readdata, snap_lo_q};
            snap_valid_d = 1'b1;
            snap_pend_d  = snap_req;
            state_d      = S_RUN;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE && state_q != S_IDLE) begin
         stop_pend_d = 1'b0;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
         snap_pend_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         load_q       <= '0;
         cont_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         tick_count_q <= '0;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
         snap_pend_q  <= 1'b0;
         snap_lo_q    <= '0;
         snap_value_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         load_q       <= load_d;
         cont_q       <= cont_d;
         stop_pend_q  <= stop_pend_d;
         tick_count_q <= tick_count_d;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
         snap_pend_q  <= snap_pend_d;
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
`endif
      end
   end

   assign cfg_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign tick_count = tick_count_q;
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
   assign snap_valid = snap_valid_d;
   assign snap_value = snap_value_d;
`else
   assign snap_valid = 1'b0;
   assign snap_value = '0;
`endif

endmodule

// File: tb/tb_nios_timer_master.sv
// Self-checking bench for nios_timer_master with a behavioural timer slave and expected-value model.
// Honours NIOS_TIMER_MASTER_SNAPSHOT_EN to check either snapshot readback or its absence.
module tb_nios_timer_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [31:0] cfg_period = '0;
   logic        cfg_continuous = 1'b0;
   logic        stop_req = 1'b0;
   logic        snap_req = 1'b0;
   logic        snap_valid;
   logic [31:0] snap_value;
   logic        tick;
   logic [15:0] tick_count;
   logic        busy;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata = '0;
   logic        irq;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_count = '0;

   // timer slave model
   logic        fire = 1'b0;
   logic        to_q = 1'b0;
   logic [31:0] counter_val = '0;
   logic [31:0] snap_reg = '0;
   logic [15:0] ctrl_reg = '0;
   logic        running = 1'b0;
   int          ctrl_writes = 0;

   assign irq = to_q;

   always #5 clk = ~clk;

   nios_timer_master dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .stop_req(stop_req),
      .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value), .tick(tick),
      .tick_count(tick_count), .busy(busy), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
   );

   always @(posedge clk) begin
      if (chipselect && !write_n) begin
         case (address)
            3'd0: begin
               to_q <= 1'b0;
               if (!ctrl_reg[1]) running <= 1'b0;
            end
            3'd1: begin
               ctrl_writes <= ctrl_writes + 1;
               ctrl_reg    <= writedata;
               if (writedata[3]) running <= 1'b0;
               else if (writedata[2]) running <= 1'b1;
            end
            3'd4: snap_reg <= counter_val;
            default: ;
         endcase
      end else if (fire) begin
         to_q <= 1'b1;
      end
      if (chipselect && write_n)
         readdata <= (address == 3'd4) ? snap_reg[15:0] :
                     (address == 3'd5) ? snap_reg[31:16] : 16'h0000;
   end

   task automatic test_reset();
      logic [72:0] got, want;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      want = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0};
      got  = {cfg_ready, busy, chipselect, write_n, address, writedata, tick, snap_valid, tick_count, snap_value};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL reset_hold: outputs=%h want=%h", got, want);
      end
      reset = 1'b0;
      @(negedge clk);
      got = {cfg_ready, busy, chipselect, write_n, address, writedata, tick, snap_valid, tick_count, snap_value};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL reset_release: outputs=%h want=%h", got, want);
      end
      exp_count = 16'h0;
      $display("txn reset outputs=%h", got);
   endtask

   task automatic do_config(input logic [31:0] period, input logic cont);
      logic [31:0] l;
      logic [2:0]  exp_a [3];
      logic [15:0] exp_d [3];
      l = (period < 32'd2) ? 32'd1 : period - 32'd1;
      exp_a = '{3'd2, 3'd3, 3'd1};
      exp_d = '{l[15:0], l[31:16], cont ? 16'h0007 : 16'h0005};
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL cfg_ready_idle: cfg_ready=%b busy=%b want 1/0", cfg_ready, busy);
      end
      cfg_valid = 1'b1;
      cfg_period = period;
      cfg_continuous = cont;
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_period = $urandom;
      cfg_continuous = ~cont;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== exp_a[i] || writedata !== exp_d[i]) begin
            failures++;
            $display("FAIL cfg_write%0d: cs=%b wn=%b addr=%0d data=%h want write addr=%0d data=%h",
                     i, chipselect, write_n, address, writedata, exp_a[i], exp_d[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0 || chipselect !== 1'b0 || running !== 1'b1) begin
         failures++;
         $display("FAIL cfg_run: busy=%b ready=%b cs=%b running=%b want 1/0/0/1", busy, cfg_ready, chipselect, running);
      end
      $display("txn config period=%h cont=%b load=%h", period, cont, l);
   endtask

   task automatic do_tick(input logic cont, input logic with_stop);
      int w;
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      if (with_stop) stop_req = 1'b1;
      @(negedge clk);
      stop_req = 1'b0;
      checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== 3'd0 || writedata !== 16'h0 || tick !== 1'b1) begin
         failures++;
         $display("FAIL tick_service: cs=%b wn=%b addr=%0d data=%h tick=%b want status write with tick",
                  chipselect, write_n, address, writedata, tick);
      end
      exp_count = exp_count + 16'd1;
      @(negedge clk);
      checks++;
      if (tick !== 1'b0 || tick_count !== exp_count || irq !== 1'b0) begin
         failures++;
         $display("FAIL tick_count: tick=%b count=%h irq=%b want 0/%h/0", tick, tick_count, irq, exp_count);
      end
      $display("txn tick count=%h cont=%b stop=%b", tick_count, cont, with_stop);
      if (!cont) begin
         w = ctrl_writes;
         checks++;
         if (busy !== 1'b0 || cfg_ready !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_idle: busy=%b ready=%b running=%b want 0/1/0", busy, cfg_ready, running);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (ctrl_writes !== w || busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_no_stop: ctrl_writes=%0d busy=%b want %0d/0", ctrl_writes, busy, w);
         end
      end else if (with_stop) begin
         checks++;
         if (chipselect !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stop_gap: cs=%b busy=%b want 0/1", chipselect, busy);
         end
         @(negedge clk);
         checks++;
         if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== 3'd1 || writedata !== 16'h0008) begin
            failures++;
            $display("FAIL stop_after_tick: cs=%b wn=%b addr=%0d data=%h want write addr=1 data=0008",
                     chipselect, write_n, address, writedata);
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || cfg_ready !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle: busy=%b ready=%b running=%b want 0/1/0", busy, cfg_ready, running);
         end
      end else begin
         checks++;
         if (busy !== 1'b1 || chipselect !== 1'b0) begin
            failures++;
            $display("FAIL tick_back_to_run: busy=%b cs=%b want 1/0", busy, chipselect);
         end
      end
   endtask

   task automatic do_stop();
      stop_req = 1'b1;
      @(negedge clk);
      stop_req = 1'b0;
      checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== 3'd1 || writedata !== 16'h0008) begin
         failures++;
         $display("FAIL stop_write: cs=%b wn=%b addr=%0d data=%h want write addr=1 data=0008",
                  chipselect, write_n, address, writedata);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1 || chipselect !== 1'b0 || running !== 1'b0) begin
         failures++;
         $display("FAIL stop_idle: busy=%b ready=%b cs=%b running=%b want 0/1/0/0", busy, cfg_ready, chipselect, running);
      end
      $display("txn stop");
   endtask

   task automatic do_snapshot(input logic [31:0] value);
`ifdef NIOS_TIMER_MASTER_SNAPSHOT_EN
      counter_val = value;
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== 3'd4 || snap_valid !== 1'b0) begin
         failures++;
         $display("FAIL snap_write: cs=%b wn=%b addr=%0d valid=%b want write addr=4", chipselect, write_n, address, snap_valid);
      end
      @(negedge clk);
      counter_val = ~value;
      checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b1 || address !== 3'd4) begin
         failures++;
         $display("FAIL snap_read_lo: cs=%b wn=%b addr=%0d want read addr=4", chipselect, write_n, address);
      end
      @(negedge clk);
      checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b1 || address !== 3'd5 || snap_valid !== 1'b0) begin
         failures++;
         $display("FAIL snap_read_hi: cs=%b wn=%b addr=%0d valid=%b want read addr=5", chipselect, write_n, address, snap_valid);
      end
      @(negedge clk);
      checks++;
      if (snap_valid !== 1'b1 || snap_value !== value || chipselect !== 1'b0) begin
         failures++;
         $display("FAIL snap_done: valid=%b value=%h cs=%b want 1/%h/0", snap_valid, snap_value, chipselect, value);
      end
      @(negedge clk);
      checks++;
      if (snap_valid !== 1'b0 || snap_value !== value || busy !== 1'b1) begin
         failures++;
         $display("FAIL snap_hold: valid=%b value=%h busy=%b want 0/%h/1", snap_valid, snap_value, busy, value);
      end
      $display("txn snapshot value=%h", snap_value);
`else
      counter_val = value;
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (chipselect !== 1'b0 || snap_valid !== 1'b0 || snap_value !== 32'h0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL snap_ignored%0d: cs=%b valid=%b value=%h busy=%b want 0/0/0/1",
                     i, chipselect, snap_valid, snap_value, busy);
         end
         @(negedge clk);
      end
      $display("txn snapshot ignored");
`endif
   endtask

   task automatic test_continuous_100();
      do_config(32'd100, 1'b1);
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_tick(1'b1, 1'b0);
      end
      do_stop();
   endtask

   task automatic test_oneshot();
      do_config(32'h0001_2345, 1'b0);
      repeat (2) @(negedge clk);
      do_tick(1'b0, 1'b0);
   endtask

   task automatic test_irq_stop();
      do_config($urandom_range(2, 5000), 1'b1);
      do_tick(1'b1, 1'b1);
      do_config($urandom_range(2, 5000), 1'b0);
      do_tick(1'b0, 1'b1);
   endtask

   task automatic test_snapshot();
      do_config(32'd1000, 1'b1);
      do_snapshot(32'h0001_0020);
      do_snapshot($urandom);
      do_tick(1'b1, 1'b0);
      do_stop();
   endtask

   task automatic test_wrap();
      do_config(32'd0, 1'b1);
      force dut.tick_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.tick_count_q;
      @(negedge clk);
      exp_count = 16'hFFFF;
      checks++;
      if (tick_count !== 16'hFFFF) begin
         failures++;
         $display("FAIL wrap_preset: count=%h want ffff", tick_count);
      end
      do_tick(1'b1, 1'b0);
      do_stop();
   endtask

   task automatic test_random();
      logic [31:0] p;
      logic        c;
      for (int n = 0; n < 8; n++) begin
         case ($urandom_range(0, 3))
            0: p = 32'd0;
            1: p = 32'd1;
            2: p = $urandom_range(2, 70000);
            default: p = $urandom;
         endcase
         c = 1'($urandom_range(0, 1));
         do_config(p, c);
         if (c) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               if ($urandom_range(0, 1) == 1) do_snapshot($urandom);
               do_tick(1'b1, 1'b0);
            end
            do_stop();
         end else begin
            do_tick(1'b0, 1'b0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int w;
      cfg_valid = 1'b1;
      cfg_period = $urandom;
      cfg_continuous = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (chipselect !== 1'b1 || address !== 3'd3) begin
         failures++;
         $display("FAIL reset_mid_phase: cs=%b addr=%0d want write addr=3", chipselect, address);
      end
      w = ctrl_writes;
      reset = 1'b1;
      #1;
      checks++;
      if (chipselect !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_abort: cs=%b busy=%b want 0/0", chipselect, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_count = 16'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (chipselect !== 1'b0 || busy !== 1'b0 || tick_count !== exp_count) begin
            failures++;
            $display("FAIL reset_mid_quiet%0d: cs=%b busy=%b count=%h want 0/0/0", i, chipselect, busy, tick_count);
         end
      end
      checks++;
      if (ctrl_writes !== w) begin
         failures++;
         $display("FAIL reset_mid_no_ctrl: ctrl_writes=%0d want %0d", ctrl_writes, w);
      end
      $display("txn reset_mid ctrl_writes=%0d", ctrl_writes);
   endtask

   initial begin
      test_reset();
      test_continuous_100();
      test_oneshot();
      test_irq_stop();
      test_snapshot();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
